hilo_mult_ctrl: RTL and testbench

Sequencer and HI/LO register owner for the shared 33-bit signed Multiplier_32 in the MIPS core. It accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO from the execute stage and drives the multiplier's start/busy handshake. It writes the 64-bit product into HI/LO and stalls the pipeline while a multiply is in flight.

---
 rtl/mips_mdu_pkg.sv | 33 +++
 rtl/hilo_mult_ctrl.sv | 118 +++++++++++
 tb/tb_hilo_mult_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings,
// controller states and multiplier operand width.
package mips_mdu_pkg;

  localparam int unsigned MUL_W = 33;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Widen a 32-bit operand to the shared signed multiplier's 33-bit input.
  function automatic logic [MUL_W-1:0] ext33(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

endpackage

// File: rtl/hilo_mult_ctrl.sv
// HI/LO register owner and start/busy sequencer for the shared 33-bit
// signed multiplier; stalls the execute stage while a multiply is in flight.
module hilo_mult_ctrl
  import mips_mdu_pkg::*;
#(
  parameter int unsigned START_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  output logic              stall,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [MUL_W-1:0]  mul_a,
  output logic [MUL_W-1:0]  mul_b,
  output logic              mul_start,
  input  logic [63:0]       mul_ab,
  input  logic              mul_busy,
  output logic [31:0]       hi,
  output logic [31:0]       lo,
  output logic              done
);

  localparam logic [2:0] HOLD_LAST = 3'(START_HOLD - 1);

  state_e             state_q;
  logic [2:0]         hold_cnt_q;
  logic               seen_busy_q;
  logic [31:0]        hi_q, lo_q, rd_data_q;
  logic [MUL_W-1:0]   mul_a_q, mul_b_q;
  logic               mul_start_q, rd_valid_q, done_q;
  logic               accept;
  op_e                op;

  assign op     = op_e'(op_code);
  // A multiply must also wait out a busy left over from an aborted operation.
  assign stall  = op_valid & ((state_q != ST_IDLE) | (is_mul(op_code) & mul_busy));
  assign accept = op_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      seen_busy_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      rd_data_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mul_a_q     <= ext33(rs_val, op == OP_MULT);
                mul_b_q     <= ext33(rt_val, op == OP_MULT);
                mul_start_q <= 1'b1;
                hold_cnt_q  <= '0;
                seen_busy_q <= 1'b0;
                state_q     <= ST_ISSUE;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              OP_MFHI: begin
                rd_data_q  <= hi_q;
                rd_valid_q <= 1'b1;
              end
              OP_MFLO: begin
                rd_data_q  <= lo_q;
                rd_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          if (mul_busy) seen_busy_q <= 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            mul_start_q <= 1'b0;
            state_q     <= ST_WAIT;
          end else begin
            hold_cnt_q <= hold_cnt_q + 3'd1;
          end
        end
        ST_WAIT: begin
          // The product is only trusted once busy has been seen and then dropped.
          if (mul_busy) seen_busy_q <= 1'b1;
          else if (seen_busy_q) state_q <= ST_WB;
        end
        ST_WB: begin
          hi_q    <= mul_ab[63:32];
          lo_q    <= mul_ab[31:0];
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Randomized bench for hilo_mult_ctrl with a behavioural multiplier and a
// HI/LO reference model computed from plain 64-bit arithmetic.
module tb_hilo_mult_ctrl;
  import mips_mdu_pkg::*;

  localparam int unsigned TB_HOLD = 5;
  localparam int          BOUND   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        stall, rd_valid, mul_start, done, mul_busy;
  logic [31:0] rd_data, hi, lo;
  logic [32:0] mul_a, mul_b;
  logic [63:0] mul_ab;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_hi = '0, ref_lo = '0;

  always #5 clk = ~clk;

  hilo_mult_ctrl #(.START_HOLD(TB_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_valid(rd_valid),
    .rd_data(rd_data), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_ab(mul_ab), .mul_busy(mul_busy), .hi(hi), .lo(lo), .done(done)
  );

  // Multiplier stand-in: busy for m_lat cycles after a start rising edge,
  // product presented when busy drops. Unaffected by the controller reset.
  logic        m_busy = 1'b0, start_d = 1'b0;
  logic [63:0] m_ab = '0, m_prod = '0;
  int          m_cnt = 0;
  int          m_lat = 3;
  logic signed [65:0] m_full;
  assign m_full   = $signed(mul_a) * $signed(mul_b);
  assign mul_busy = m_busy;
  assign mul_ab   = m_ab;

  always @(posedge clk) begin
    start_d <= mul_start;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_ab   <= m_prod;
      end
      m_cnt <= m_cnt - 1;
    end else if (mul_start && !start_d) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
      m_prod <= m_full[63:0];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    int ia, ib;
    longint unsigned ua, ub;
    ia = a; ib = b; ua = 64'(a); ub = 64'(b);
    if (op == OP_MULT) return longint'(ia) * longint'(ib);
    return ua * ub;
  endfunction

  // Present one op, wait for acceptance, then check its architectural effect.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    int n, sc;
    logic [63:0] p;
    @(negedge clk);
    op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
    #1;
    stalls = 0;
    while (stall && stalls < BOUND) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stall) begin
      chk("accept_timeout", 64'(stall), 64'd0);
      op_valid = 1'b0;
      return;
    end
    if (is_mul(op)) chk("busy_at_accept", 64'(mul_busy), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_NOP;
    case (op)
      OP_MULT, OP_MULTU: begin
        p = ref_prod(op, a, b);
        sc = 0; n = 0;
        while (!done && n < BOUND) begin
          if (mul_start) sc++;
          @(posedge clk); #1;
          n++;
        end
        chk("done", 64'(done), 64'd1);
        ref_hi = p[63:32]; ref_lo = p[31:0];
        chk("mul_hi", 64'(hi), 64'(ref_hi));
        chk("mul_lo", 64'(lo), 64'(ref_lo));
        chk("start_len", 64'(sc), 64'(TB_HOLD));
      end
      OP_MTHI: begin ref_hi = a; chk("mthi", 64'(hi), 64'(ref_hi)); end
      OP_MTLO: begin ref_lo = a; chk("mtlo", 64'(lo), 64'(ref_lo)); end
      OP_MFHI: begin
        chk("mfhi_valid", 64'(rd_valid), 64'd1);
        chk("mfhi_data", 64'(rd_data), 64'(ref_hi));
      end
      OP_MFLO: begin
        chk("mflo_valid", 64'(rd_valid), 64'd1);
        chk("mflo_data", 64'(rd_data), 64'(ref_lo));
      end
      default: begin
        chk("nop_hilo", {hi, lo}, {ref_hi, ref_lo});
        chk("nop_rdv", 64'(rd_valid), 64'd0);
      end
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int st, n, sc;
    logic acc_done;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle while rd_valid is high.
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, st);
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, st);
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_MFHI;
    @(posedge clk); #2;
    op_valid = 1'b0; op_code = OP_NOP;
    rst_n = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_start", 64'(mul_start), 64'd0);
    chk("arst_rdv", 64'(rd_valid), 64'd0);
    ref_hi = '0; ref_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products.
    m_lat = 4;
    run_op(OP_MULT,  32'd3,         32'd17, st);
    run_op(OP_MULT,  32'hFFFF_FFF9, 32'hFFFF_FFF9, st);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, st);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, st);

    // MFLO held right behind a multiply: accepted only once back in IDLE.
    m_lat = 7;
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'd3; rt_val = 32'd17;
    @(posedge clk); #1;
    op_code = OP_MFLO;
    n = 0; sc = 0; acc_done = 1'b0;
    while (stall && n < BOUND) begin
      if (mul_start) sc++;
      @(posedge clk); #1;
      n++;
    end
    acc_done = done;
    chk("mflo_held_until_done", 64'(acc_done), 64'd1);
    chk("mflo_held_start_len", 64'(sc), 64'(TB_HOLD));
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_NOP;
    chk("mflo_after_mult_v", 64'(rd_valid), 64'd1);
    chk("mflo_after_mult_d", 64'(rd_data), 64'd51);
    ref_hi = 32'd0; ref_lo = 32'd51;

    // MTHI then MFHI back to back.
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, st);
    run_op(OP_MFHI, 32'd0, 32'd0, st);
    chk("mfhi_b2b_stall", 64'(st), 64'd0);
    chk("mfhi_b2b_data", 64'(rd_data), 64'hDEAD_BEEF);

    // Reset during WAIT with the multiplier still busy.
    m_lat = 25;
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = OP_NOP;
    repeat (TB_HOLD + 3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("wait_rst_hilo", {hi, lo}, 64'd0);
    chk("wait_rst_start", 64'(mul_start), 64'd0);
    ref_hi = '0; ref_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_not_written", {hi, lo}, 64'd0);
    m_lat = 3;
    run_op(OP_MULT, 32'd3, 32'd17, st);
    chk("post_abort_stalled", 64'(st > 0), 64'd1);

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      m_lat = $urandom_range(1, 12);
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
